mem_uart_bridge: RTL and testbench
==================================

Name: mem_uart_bridge

Overview:
- CPU-side master of the UART memory link. Converts one native memory request (valid/ready, 32-bit address/data, 4-bit write strobe) into the link byte protocol, then completes the request when the response arrives.
- Sits between the RISC-V core memory port and the UART core's AXI-stream byte interfaces. The far end of the link is the host memory model.

Parameters:
- AckByte, 8'hC8, write-acknowledge byte expected from the far end.
- ReadCmd, 8'h77, command byte for reads.
- TimeoutCycles, 32'd1000000, response watchdog limit in clk_i cycles (used only with the optional feature).

Ports:
- clk_i  input  1  clock
- reset_ni  input  1  asynchronous active-low reset
- mem_valid_i  input  1  request valid from core
- mem_addr_i  input  32  byte address
- mem_wdata_i  input  32  write data
- mem_wstrb_i  input  4  byte strobes; 0 = read
- mem_ready_o  output  1  one-cycle completion pulse
- mem_rdata_o  output  32  read data, valid while mem_ready_o=1
- tx_tdata_o  output  8  byte to UART transmitter
- tx_tvalid_o  output  1  byte valid
- tx_tready_i  input  1  UART transmitter accepts byte
- rx_tdata_i  input  8  byte from UART receiver
- rx_tvalid_i  input  1  received byte valid
- rx_tready_o  output  1  bridge consumes received byte
- err_o  output  1  sticky protocol error flag

Behaviour:
- Reset (async, reset_ni=0): state IDLE. mem_ready_o=0, mem_rdata_o=0, tx_tdata_o=0, tx_tvalid_o=0, rx_tready_o=0, err_o=0. Byte index and watchdog counters are 0.
- Reset asserted mid-transaction aborts it immediately. No partial response is ever signalled. The far end may be left mid-frame; resynchronising it is out of scope.
- IDLE: when mem_valid_i=1 and mem_ready_o=0, latch addr, wdata and wstrb. Next state is CMD. Later changes on the mem_* inputs are ignored until completion.
- CMD: tx_tvalid_o=1. tx_tdata_o = ReadCmd if wstrb==0, else {4'h2, wstrb}. Leave the state on the edge where tx_tvalid_o and tx_tready_i are both 1.
- ADDR: send 4 bytes of addr, LSB first, with the same valid/ready rule per byte. tx_tvalid_o stays high between bytes; the next byte is presented the cycle after acceptance.
- After ADDR: reads go to RDATA; writes go to WDATA, which sends wdata as 4 bytes, LSB first.
- Every byte is sent; wstrb only encodes the command, and the data is not masked.
- WDATA leads to ACK.
- RDATA: rx_tready_o=1. Each byte is taken when rx_tvalid_i and rx_tready_o are both 1, assembled LSB first into mem_rdata_o. After the 4th byte, go to DONE.
- ACK: rx_tready_o=1. Consume one byte. If it is not AckByte, set err_o. Go to DONE either way.
- DONE: mem_ready_o=1 for exactly one cycle, then IDLE.
  - mem_rdata_o holds its value until the next read completes.
  - Writes leave mem_rdata_o unchanged.
- rx_tready_o=0 outside RDATA and ACK, so stray received bytes stall in the UART.
- tx_tvalid_o=0 outside CMD, ADDR and WDATA.
- Back-to-back: mem_valid_i still high in the cycle after DONE starts a new request. Minimum turnaround is IDLE→CMD with one idle cycle.
- Minimum latency with ready always high and rx bytes immediate:
  - read: 1 + 1 + 4 + 4 + 1 cycles;
  - write: 1 + 1 + 4 + 4 + 1 + 1 cycles.
- err_o is cleared only by reset.

Optional Feature:
- Macro MEM_UART_BRIDGE_TIMEOUT_EN.
- Defined:
  - A 32-bit counter runs while in RDATA or ACK and is cleared on every accepted rx byte.
  - When it reaches TimeoutCycles: set err_o, set mem_rdata_o=32'hDEADBEEF for a read (a write leaves it unchanged), go to DONE, and complete with mem_ready_o.
  - Partially received read bytes are discarded.
- Not defined: no counter. RDATA and ACK wait indefinitely.

Test Plan:
- Read 0x000003FC, far end answers bytes 0x44,0x33,0x22,0x11:
  - tx sees 0x77,0xFC,0x03,0x00,0x00;
  - mem_ready_o pulses once with mem_rdata_o=0x11223344;
  - err_o=0.
- Write addr 0x00000010, wdata 0xA5A5_0F0F, wstrb 4'b0011, ack 0xC8:
  - tx sees 0x23,0x10,0x00,0x00,0x00,0x0F,0x0F,0xA5,0xA5;
  - one ready pulse; err_o=0.
- Write with ack 0x55 -> ready pulses, err_o=1 and stays 1 through a following good read.
- tx_tready_i toggled every other cycle and rx_tvalid_i delayed 20 cycles per byte:
  - identical byte sequence, no byte duplicated or dropped;
  - ready only after the 4th rx byte.
- reset_ni pulsed low during ADDR byte 2:
  - all outputs go to reset values asynchronously;
  - no mem_ready_o;
  - a fresh read afterward completes normally.
- With MEM_UART_BRIDGE_TIMEOUT_EN and TimeoutCycles=50, read where the far end sends 2 bytes then stops:
  - ready pulses 50 cycles after the 2nd byte;
  - mem_rdata_o=0xDEADBEEF, err_o=1.

Source files
------------

// File: rtl/mem_uart_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_uart_bridge
// Brief    : Link master that turns one native memory request into UART link
//            bytes and completes it when the far end answers.
//            Optional macro MEM_UART_BRIDGE_TIMEOUT_EN adds a response watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module mem_uart_bridge #(
    parameter logic [7:0]  ACK_BYTE       = 8'hC8,
    parameter logic [7:0]  READ_CMD       = 8'h77,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wstrb_i,
    output logic        mem_ready_o,
    output logic [31:0] mem_rdata_o,
    output logic [7:0]  tx_tdata_o,
    output logic        tx_tvalid_o,
    input  logic        tx_tready_i,
    input  logic [7:0]  rx_tdata_i,
    input  logic        rx_tvalid_i,
    output logic        rx_tready_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_ADDR  = 3'd2,
        S_WDATA = 3'd3,
        S_RDATA = 3'd4,
        S_ACK   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [1:0]  r_idx;
    logic [23:0] r_rbuf;

`ifdef MEM_UART_BRIDGE_TIMEOUT_EN
    localparam logic [31:0] C_TIMEOUT_RDATA = 32'hDEADBEEF;
    logic [31:0] r_wdog;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

    function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_idx       <= '0;
            r_rbuf      <= '0;
            mem_ready_o <= 1'b0;
            mem_rdata_o <= '0;
            tx_tdata_o  <= '0;
            tx_tvalid_o <= 1'b0;
            rx_tready_o <= 1'b0;
            err_o       <= 1'b0;
`ifdef MEM_UART_BRIDGE_TIMEOUT_EN
            r_wdog      <= '0;
`endif
        end else begin
            mem_ready_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mem_valid_i && !mem_ready_o) begin
                        r_addr      <= mem_addr_i;
                        r_wdata     <= mem_wdata_i;
                        r_wstrb     <= mem_wstrb_i;
                        r_idx       <= '0;
                        tx_tvalid_o <= 1'b1;
                        tx_tdata_o  <= (mem_wstrb_i == 4'h0) ? READ_CMD : {4'h2, mem_wstrb_i};
                        r_state     <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (tx_tready_i) begin
                        tx_tdata_o <= r_addr[7:0];
                        r_idx      <= '0;
                        r_state    <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (tx_tready_i) begin
                        if (r_idx == 2'd3) begin
                            r_idx <= '0;
                            if (r_wstrb == 4'h0) begin
                                tx_tvalid_o <= 1'b0;
                                rx_tready_o <= 1'b1;
                                r_state     <= S_RDATA;
                            end else begin
                                tx_tdata_o <= r_wdata[7:0];
                                r_state    <= S_WDATA;
                            end
                        end else begin
                            r_idx      <= r_idx + 2'd1;
                            tx_tdata_o <= byte_of(r_addr, r_idx + 2'd1);
                        end
                    end
                end
                S_WDATA: begin
                    if (tx_tready_i) begin
                        if (r_idx == 2'd3) begin
                            r_idx       <= '0;
                            tx_tvalid_o <= 1'b0;
                            rx_tready_o <= 1'b1;
                            r_state     <= S_ACK;
                        end else begin
                            r_idx      <= r_idx + 2'd1;
                            tx_tdata_o <= byte_of(r_wdata, r_idx + 2'd1);
                        end
                    end
                end
                S_RDATA: begin
                    if (rx_tvalid_i) begin
                        if (r_idx == 2'd3) begin
                            // Commit all four bytes at once so a partial read never leaks out
                            mem_rdata_o <= {rx_tdata_i, r_rbuf};
                            r_idx       <= '0;
                            rx_tready_o <= 1'b0;
                            mem_ready_o <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_rbuf <= {rx_tdata_i, r_rbuf[23:8]};
                            r_idx  <= r_idx + 2'd1;
                        end
                    end
                end
                S_ACK: begin
                    if (rx_tvalid_i) begin
                        if (rx_tdata_i != ACK_BYTE) begin
                            err_o <= 1'b1;
                        end
                        rx_tready_o <= 1'b0;
                        mem_ready_o <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    tx_tvalid_o <= 1'b0;
                    rx_tready_o <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase

`ifdef MEM_UART_BRIDGE_TIMEOUT_EN
            // Watchdog overrides the state decode above when it expires
            if ((r_state == S_RDATA) || (r_state == S_ACK)) begin
                if (rx_tvalid_i) begin
                    r_wdog <= '0;
                end else if (r_wdog == TIMEOUT_CYCLES - 32'd1) begin
                    r_wdog      <= '0;
                    r_idx       <= '0;
                    err_o       <= 1'b1;
                    rx_tready_o <= 1'b0;
                    mem_ready_o <= 1'b1;
                    r_state     <= S_DONE;
                    if (r_state == S_RDATA) begin
                        mem_rdata_o <= C_TIMEOUT_RDATA;
                    end
                end else begin
                    r_wdog <= r_wdog + 32'd1;
                end
            end else begin
                r_wdog <= '0;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_uart_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_uart_bridge
// Brief    : Self-checking bench for mem_uart_bridge with a transaction-level
//            model of the link frame, read data and sticky error flag.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_uart_bridge;

    logic        clk_i       = 1'b0;
    logic        reset_ni    = 1'b0;
    logic        mem_valid_i = 1'b0;
    logic [31:0] mem_addr_i  = '0;
    logic [31:0] mem_wdata_i = '0;
    logic [3:0]  mem_wstrb_i = '0;
    logic        tx_tready_i = 1'b0;
    logic [7:0]  rx_tdata_i  = '0;
    logic        rx_tvalid_i = 1'b0;
    logic        mem_ready_o;
    logic [31:0] mem_rdata_o;
    logic [7:0]  tx_tdata_o;
    logic        tx_tvalid_o;
    logic        rx_tready_o;
    logic        err_o;

    mem_uart_bridge dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .mem_valid_i (mem_valid_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_wstrb_i (mem_wstrb_i),
        .mem_ready_o (mem_ready_o),
        .mem_rdata_o (mem_rdata_o),
        .tx_tdata_o  (tx_tdata_o),
        .tx_tvalid_o (tx_tvalid_o),
        .tx_tready_i (tx_tready_i),
        .rx_tdata_i  (rx_tdata_i),
        .rx_tvalid_i (rx_tvalid_i),
        .rx_tready_o (rx_tready_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    int          tests_run = 0;
    int          fail_cnt  = 0;
    int          cyc       = 0;
    int          ready_cnt = 0;
    int          ready_cyc = 0;
    logic [31:0] ready_rdata = '0;
    logic [7:0]  tx_q[$];
    int          tx_cyc_q[$];
    logic [7:0]  exp_tx[$];
    int          tr_mode   = 0;
    logic        model_err = 1'b0;
    logic [31:0] model_rdata = '0;
    int          rdy0      = 0;
    int          drive_cyc = 0;

    // Observe the link at the falling edge, where all handshake signals are settled
    always @(negedge clk_i) begin
        cyc++;
        if (reset_ni && tx_tvalid_o && tx_tready_i) begin
            tx_q.push_back(tx_tdata_o);
            tx_cyc_q.push_back(cyc);
        end
        if (mem_ready_o) begin
            ready_cnt++;
            ready_cyc   = cyc;
            ready_rdata = mem_rdata_o;
        end
    end

    always @(posedge clk_i) begin
        #1;
        case (tr_mode)
            0:       tx_tready_i = 1'b1;
            1:       tx_tready_i = ~tx_tready_i;
            default: tx_tready_i = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic build_exp(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
        exp_tx.delete();
        exp_tx.push_back((s == 4'h0) ? 8'h77 : {4'h2, s});
        for (int i = 0; i < 4; i++) exp_tx.push_back(a[8*i +: 8]);
        if (s != 4'h0)
            for (int i = 0; i < 4; i++) exp_tx.push_back(w[8*i +: 8]);
    endtask

    task automatic start_req(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
        build_exp(a, w, s);
        tx_q.delete();
        tx_cyc_q.delete();
        rdy0        = ready_cnt;
        drive_cyc   = cyc;
        mem_addr_i  = a;
        mem_wdata_i = w;
        mem_wstrb_i = s;
        mem_valid_i = 1'b1;
        @(posedge clk_i); #1;
        mem_valid_i = 1'b0;
        mem_addr_i  = $urandom;
        mem_wdata_i = $urandom;
        mem_wstrb_i = 4'($urandom);
    endtask

    // Far end: answers n bytes (LSB of rb first), optionally only after the full frame
    task automatic respond(input logic [31:0] rb, input int n, input int dly, input bit eager);
        int g;
        if (!eager) begin
            g = 0;
            while (tx_q.size() < exp_tx.size() && g < 400) begin
                @(negedge clk_i); #1; g++;
            end
            @(posedge clk_i); #1;
        end
        for (int k = 0; k < n; k++) begin
            if (dly > 0) begin
                rx_tvalid_i = 1'b0;
                repeat (dly) @(posedge clk_i);
                #1;
            end
            rx_tdata_i  = rb[8*k +: 8];
            rx_tvalid_i = 1'b1;
            g = 0;
            do begin
                @(negedge clk_i); #1; g++;
            end while (!rx_tready_o && g < 200);
            tests_run++;
            if (!rx_tready_o) begin
                fail_cnt++;
                $display("FAIL rx_handshake: byte %0d never consumed, rx_tready_o=%0b required 1", k, rx_tready_o);
                rx_tvalid_i = 1'b0;
                return;
            end
            tests_run++;
            if (tx_q.size() != exp_tx.size()) begin
                fail_cnt++;
                $display("FAIL rx_before_frame: tx bytes sent %0d, required %0d before rx byte %0d", tx_q.size(), exp_tx.size(), k);
            end
            tests_run++;
            if (ready_cnt != rdy0) begin
                fail_cnt++;
                $display("FAIL early_ready: %0d pulses before rx byte %0d, required 0", ready_cnt - rdy0, k);
            end
            @(posedge clk_i); #1;
            rx_tvalid_i = 1'b0;
        end
    endtask

    task automatic finish_txn(input string name, input int exp_lat);
        int g;
        int bad;
        g = 0;
        while (ready_cnt == rdy0 && g < 100) begin
            @(negedge clk_i); #1; g++;
        end
        repeat (2) begin
            @(negedge clk_i); #1;
        end
        tests_run++;
        if (ready_cnt != rdy0 + 1) begin
            fail_cnt++;
            $display("FAIL %s ready_pulses: got %0d required 1", name, ready_cnt - rdy0);
        end
        tests_run++;
        if (ready_rdata !== model_rdata) begin
            fail_cnt++;
            $display("FAIL %s rdata: got %08h required %08h", name, ready_rdata, model_rdata);
        end
        tests_run++;
        if (err_o !== model_err) begin
            fail_cnt++;
            $display("FAIL %s err: got %0b required %0b", name, err_o, model_err);
        end
        bad = 0;
        if (tx_q.size() == exp_tx.size())
            for (int i = 0; i < exp_tx.size(); i++) if (tx_q[i] !== exp_tx[i]) bad++;
        tests_run++;
        if (tx_q.size() != exp_tx.size() || bad != 0) begin
            fail_cnt++;
            $display("FAIL %s tx_bytes: got %0d bytes (%0d wrong) required %0d bytes", name, tx_q.size(), bad, exp_tx.size());
        end
        tests_run++;
        if ({mem_rdata_o, tx_tvalid_o, rx_tready_o} !== {model_rdata, 1'b0, 1'b0}) begin
            fail_cnt++;
            $display("FAIL %s idle_outputs: rdata=%08h txv=%0b rxr=%0b required %08h 0 0", name, mem_rdata_o, tx_tvalid_o, rx_tready_o, model_rdata);
        end
        if (exp_lat > 0) begin
            tests_run++;
            if (ready_cyc - drive_cyc != exp_lat) begin
                fail_cnt++;
                $display("FAIL %s latency: got %0d required %0d", name, ready_cyc - drive_cyc, exp_lat);
            end
        end
        @(posedge clk_i); #1;
    endtask

    task automatic do_txn(input string name, input logic [31:0] a, input logic [31:0] w, input logic [3:0] s,
                          input logic [31:0] rb, input logic [7:0] ack, input int dly, input bit eager, input int exp_lat);
        start_req(a, w, s);
        if (s == 4'h0) begin
            respond(rb, 4, dly, eager);
            model_rdata = rb;
        end else begin
            respond({24'h0, ack}, 1, dly, eager);
            if (ack != 8'hC8) model_err = 1'b1;
        end
        finish_txn(name, exp_lat);
    endtask

    task automatic check_reset_outputs(input string name);
        tests_run++;
        if ({mem_ready_o, mem_rdata_o, tx_tdata_o, tx_tvalid_o, rx_tready_o, err_o} !== 44'h0) begin
            fail_cnt++;
            $display("FAIL %s: ready=%0b rdata=%08h txd=%02h txv=%0b rxr=%0b err=%0b required all 0", name,
                     mem_ready_o, mem_rdata_o, tx_tdata_o, tx_tvalid_o, rx_tready_o, err_o);
        end
    endtask

    task automatic test_reset();
        reset_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        check_reset_outputs("reset_values");
        @(posedge clk_i); #1;
        reset_ni = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_outputs("after_reset_idle");
    endtask

    task automatic test_read();
        tr_mode = 0;
        do_txn("read_3fc", 32'h0000_03FC, $urandom, 4'h0, 32'h1122_3344, 8'h00, 0, 1'b1, 11);
    endtask

    task automatic test_write();
        tr_mode = 0;
        do_txn("write_10", 32'h0000_0010, 32'hA5A5_0F0F, 4'b0011, 32'h0, 8'hC8, 0, 1'b1, 12);
    endtask

    task automatic test_bad_ack();
        tr_mode = 0;
        do_txn("write_bad_ack", $urandom, $urandom, 4'b1111, 32'h0, 8'h55, 0, 1'b1, 12);
        do_txn("read_after_err", $urandom, $urandom, 4'h0, $urandom, 8'h00, 0, 1'b1, 11);
    endtask

    task automatic test_slow_link();
        tr_mode = 1;
        do_txn("slow_read", $urandom, $urandom, 4'h0, $urandom, 8'h00, 20, 1'b0, 0);
        do_txn("slow_write", $urandom, $urandom, 4'b0100, 32'h0, 8'hC8, 20, 1'b0, 0);
        tr_mode = 0;
    endtask

    task automatic test_random();
        logic [3:0] s;
        logic [7:0] ack;
        tr_mode = 2;
        for (int t = 0; t < 8; t++) begin
            s   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            ack = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hC8;
            do_txn("random", $urandom, $urandom, s, $urandom, ack, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0);
        end
        tr_mode = 0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, rb1, a2, w2;
        int          done_cyc;
        int          g;
        tr_mode = 0;
        a1  = $urandom; rb1 = $urandom; a2 = $urandom; w2 = $urandom;
        build_exp(a1, 32'h0, 4'h0);
        tx_q.delete(); tx_cyc_q.delete();
        rdy0 = ready_cnt;
        mem_addr_i = a1; mem_wdata_i = 32'h0; mem_wstrb_i = 4'h0; mem_valid_i = 1'b1;
        @(posedge clk_i); #1;
        mem_addr_i = a2; mem_wdata_i = w2; mem_wstrb_i = 4'b1001;
        respond(rb1, 4, 0, 1'b1);
        g = 0;
        while (ready_cnt == rdy0 && g < 20) begin
            @(negedge clk_i); #1; g++;
        end
        model_rdata = rb1;
        done_cyc    = ready_cyc;
        tests_run++;
        if (ready_cnt != rdy0 + 1 || ready_rdata !== model_rdata) begin
            fail_cnt++;
            $display("FAIL b2b_first: pulses=%0d rdata=%08h required 1 %08h", ready_cnt - rdy0, ready_rdata, model_rdata);
        end
        tests_run++;
        if (tx_q.size() != 5 || tx_q[0] !== 8'h77 || tx_q[1] !== a1[7:0] || tx_q[4] !== a1[31:24]) begin
            fail_cnt++;
            $display("FAIL b2b_first_frame: got %0d bytes required 5 (read of %08h)", tx_q.size(), a1);
        end
        build_exp(a2, w2, 4'b1001);
        tx_q.delete(); tx_cyc_q.delete();
        rdy0 = ready_cnt;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        mem_valid_i = 1'b0;
        respond({24'h0, 8'hC8}, 1, 0, 1'b1);
        tests_run++;
        if (tx_cyc_q.size() == 0 || tx_cyc_q[0] != done_cyc + 2) begin
            fail_cnt++;
            $display("FAIL b2b_turnaround: cmd at cycle %0d required %0d", (tx_cyc_q.size() != 0) ? tx_cyc_q[0] : -1, done_cyc + 2);
        end
        finish_txn("b2b_second", 0);
    endtask

    task automatic test_reset_mid();
        int g;
        tr_mode = 0;
        start_req($urandom, $urandom, 4'b0110);
        g = 0;
        while (tx_q.size() < 3 && g < 50) begin
            @(negedge clk_i); #1; g++;
        end
        @(posedge clk_i); #2;
        reset_ni = 1'b0;
        #1;
        check_reset_outputs("mid_reset_async");
        model_err   = 1'b0;
        model_rdata = 32'h0;
        repeat (3) @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
        tests_run++;
        if (ready_cnt != rdy0) begin
            fail_cnt++;
            $display("FAIL mid_reset_ready: got %0d pulses required 0", ready_cnt - rdy0);
        end
        @(posedge clk_i); #1;
        do_txn("read_after_reset", $urandom, $urandom, 4'h0, $urandom, 8'h00, 0, 1'b1, 11);
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_bad_ack();
        test_slow_link();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
`default_nettype wire
